// File: rtl/pll_lock_supervisor_pkg.sv
// Shared FSM encoding and constant helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Flop-chain synchronizer bringing the asynchronous PLL LOCK into the reference clock domain.
module pll_lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL RST from the reference clock, waits for stable lock, then releases the system reset.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOSS_CNT_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  pll_locked_i,
  input  logic                  clear_status_i,
  output logic                  pll_rst_o,
  output logic                  sys_reset_o,
  output logic                  ready_o,
  output logic                  lock_lost_o,
  output logic [LOSS_CNT_W-1:0] loss_count_o
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_END = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_END = CNT_W'(STABLE_CYCLES - 1);

  logic                  locked_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  loss_ev;
  logic                  pll_rst_q, sys_reset_q, ready_q, lock_lost_q;
  logic [LOSS_CNT_W-1:0] loss_count_q;

  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (pll_locked_i),
    .q_o     (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    loss_ev = 1'b0;
    case (state_q)
      PLL_RESET: if (cnt_q == RST_END) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)              state_d = STABLE;
        else if (cnt_q == TO_END)  state_d = PLL_RESET;
      end
      STABLE: begin
        if (!locked_s)             state_d = WAIT_LOCK;
        else if (cnt_q == STB_END) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = PLL_RESET;
          loss_ev = 1'b1;
        end
      end
      default: state_d = PLL_RESET;
    endcase
    // every state change restarts the shared counter, including glitch returns to WAIT_LOCK
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= PLL_RESET;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= (state_d == PLL_RESET);
      sys_reset_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      // a loss on the same edge as clear_status still records that loss
      if (loss_ev) begin
        lock_lost_q <= 1'b1;
        if (clear_status_i)        loss_count_q <= LOSS_CNT_W'(1);
        else if (loss_count_q != '1) loss_count_q <= loss_count_q + LOSS_CNT_W'(1);
      end else if (clear_status_i) begin
        lock_lost_q  <= 1'b0;
        loss_count_q <= '0;
      end
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign sys_reset_o  = sys_reset_q;
  assign ready_o      = ready_q;
  assign lock_lost_o  = lock_lost_q;
  assign loss_count_o = loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clear_status = 1'b0;
  logic       pll_rst, sys_reset, ready, lock_lost;
  logic [1:0] loss_count;

  int passed = 0;
  int total  = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(64),
    .STABLE_CYCLES(8), .LOSS_CNT_W(2)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .pll_locked_i   (pll_locked),
    .clear_status_i (clear_status),
    .pll_rst_o      (pll_rst),
    .sys_reset_o    (sys_reset),
    .ready_o        (ready),
    .lock_lost_o    (lock_lost),
    .loss_count_o   (loss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reset held over three edges; returns just after the last edge that sampled reset high
  task automatic do_reset(input logic lk);
    pll_locked = lk;
    reset = 1'b1;
    tick; tick; tick;
    reset = 1'b0;
  endtask

  task automatic count_rst_high(output int n);
    n = 0;
    while (pll_rst && n < 20) begin n++; tick; end
  endtask

  task automatic ticks_until_ready(output int n);
    n = 0;
    do begin tick; n++; end while (!ready && n < 40);
  endtask

  task automatic test_reset;
    reset = 1'b1; pll_locked = 1'b0;
    tick; tick;
    total++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst got=%0b exp=1", pll_rst); else passed++;
    total++; if (sys_reset !== 1'b1) $display("FAIL reset_sys_reset got=%0b exp=1", sys_reset); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", ready); else passed++;
    total++; if (lock_lost !== 1'b0) $display("FAIL reset_lock_lost got=%0b exp=0", lock_lost); else passed++;
    total++; if (loss_count !== 2'd0) $display("FAIL reset_loss_count got=%0d exp=0", loss_count); else passed++;
  endtask

  task automatic test_lock;
    int n;
    do_reset(1'b0);
    count_rst_high(n);
    total++; if (n !== 4) $display("FAIL lock_pll_rst_len got=%0d exp=4", n); else passed++;
    pll_locked = 1'b1;
    n = 0;
    do begin tick; n++; end while (sys_reset && n < 40);
    total++; if (n !== 11) $display("FAIL lock_release_delay got=%0d exp=11", n); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL lock_ready got=%0b exp=1", ready); else passed++;
    total++; if (pll_rst !== 1'b0) $display("FAIL lock_pll_rst got=%0b exp=0", pll_rst); else passed++;
  endtask

  task automatic test_timeout;
    int n;
    logic seen_rel;
    seen_rel = 1'b0;
    do_reset(1'b0);
    count_rst_high(n);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!pll_rst && n < 100) begin
        if (!sys_reset) seen_rel = 1'b1;
        tick; n++;
      end
      total++; if (n !== 64) $display("FAIL timeout_wait_len[%0d] got=%0d exp=64", k, n); else passed++;
      count_rst_high(n);
      total++; if (n !== 4) $display("FAIL timeout_rst_len[%0d] got=%0d exp=4", k, n); else passed++;
    end
    total++; if (seen_rel !== 1'b0) $display("FAIL timeout_sys_reset_released got=%0b exp=0", seen_rel); else passed++;
    total++; if (loss_count !== 2'd0) $display("FAIL timeout_loss_count got=%0d exp=0", loss_count); else passed++;
  endtask

  task automatic test_glitch;
    int n;
    do_reset(1'b1);
    for (int k = 0; k < 7; k++) tick;   // now just past E7, STABLE for 2 cycles
    pll_locked = 1'b0;
    tick;
    pll_locked = 1'b1;
    ticks_until_ready(n);
    total++; if (n !== 11) $display("FAIL glitch_restart_delay got=%0d exp=11", n); else passed++;
    total++; if (sys_reset !== 1'b0) $display("FAIL glitch_sys_reset got=%0b exp=0", sys_reset); else passed++;
    total++; if (lock_lost !== 1'b0 || loss_count !== 2'd0)
      $display("FAIL glitch_no_loss got=%0b/%0d exp=0/0", lock_lost, loss_count); else passed++;
  endtask

  task automatic test_loss;
    int n;
    pll_locked = 1'b0;
    tick; tick;
    total++; if (sys_reset !== 1'b0 || ready !== 1'b1)
      $display("FAIL loss_early got=%0b/%0b exp=0/1", sys_reset, ready); else passed++;
    tick;
    total++; if ({pll_rst, sys_reset, ready} !== 3'b110)
      $display("FAIL loss_outputs got=%b exp=110", {pll_rst, sys_reset, ready}); else passed++;
    total++; if (lock_lost !== 1'b1 || loss_count !== 2'd1)
      $display("FAIL loss_status got=%0b/%0d exp=1/1", lock_lost, loss_count); else passed++;
    pll_locked = 1'b1;
    ticks_until_ready(n);
    total++; if (n !== 13) $display("FAIL loss_relock_delay got=%0d exp=13", n); else passed++;
  endtask

  task automatic lose_and_relock;
    int n;
    pll_locked = 1'b0;
    tick; tick; tick;
    pll_locked = 1'b1;
    ticks_until_ready(n);
  endtask

  task automatic test_saturate;
    lose_and_relock;
    total++; if (loss_count !== 2'd2) $display("FAIL sat_count2 got=%0d exp=2", loss_count); else passed++;
    lose_and_relock;
    lose_and_relock;
    lose_and_relock;
    total++; if (loss_count !== 2'd3) $display("FAIL sat_count5 got=%0d exp=3", loss_count); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL sat_ready got=%0b exp=1", ready); else passed++;
    clear_status = 1'b1;
    tick;
    clear_status = 1'b0;
    total++; if (lock_lost !== 1'b0 || loss_count !== 2'd0)
      $display("FAIL clear_status got=%0b/%0d exp=0/0", lock_lost, loss_count); else passed++;
    pll_locked = 1'b0;
    tick; tick;
    clear_status = 1'b1;
    tick;
    clear_status = 1'b0;
    total++; if (lock_lost !== 1'b1 || loss_count !== 2'd1)
      $display("FAIL clear_vs_loss got=%0b/%0d exp=1/1", lock_lost, loss_count); else passed++;
    pll_locked = 1'b1;
  endtask

  task automatic test_reset_in_run;
    int n;
    ticks_until_ready(n);
    total++; if (ready !== 1'b1) $display("FAIL rir_pre_run got=%0b exp=1", ready); else passed++;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if ({pll_rst, sys_reset, ready} !== 3'b110)
      $display("FAIL rir_outputs got=%b exp=110", {pll_rst, sys_reset, ready}); else passed++;
    total++; if (lock_lost !== 1'b0 || loss_count !== 2'd0)
      $display("FAIL rir_status got=%0b/%0d exp=0/0", lock_lost, loss_count); else passed++;
    count_rst_high(n);
    total++; if (n !== 4) $display("FAIL rir_pll_rst_len got=%0d exp=4", n); else passed++;
    ticks_until_ready(n);
    total++; if (n !== 9) $display("FAIL rir_relock_delay got=%0d exp=9", n); else passed++;
  endtask

  initial begin
    test_reset;
    test_lock;
    test_timeout;
    test_glitch;
    test_loss;
    test_saturate;
    test_reset_in_run;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
